// File: rtl/ov7670_pkg.sv
// Shared constants, FSM encoding and RGB444 colour table for the OV7670 capture path.
package ov7670_pkg;

    localparam int H_PIX     = 320;
    localparam int V_LINES   = 240;
    localparam int FRAME_PIX = H_PIX * V_LINES;
    localparam int ADDR_W    = 17;
    localparam int DATA_W    = 12;

    localparam logic [11:0] RGB_WHITE   = 12'hFFF;
    localparam logic [11:0] RGB_YELLOW  = 12'hFF0;
    localparam logic [11:0] RGB_CYAN    = 12'h0FF;
    localparam logic [11:0] RGB_GREEN   = 12'h0F0;
    localparam logic [11:0] RGB_MAGENTA = 12'hF0F;
    localparam logic [11:0] RGB_RED     = 12'hF00;
    localparam logic [11:0] RGB_BLUE    = 12'h00F;
    localparam logic [11:0] RGB_BLACK   = 12'h000;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } fwc_state_e;

    function automatic logic [11:0] bar_colour(input int unsigned idx);
        case (idx)
            0:       return RGB_WHITE;
            1:       return RGB_YELLOW;
            2:       return RGB_CYAN;
            3:       return RGB_GREEN;
            4:       return RGB_MAGENTA;
            5:       return RGB_RED;
            6:       return RGB_BLUE;
            default: return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/fwc_pattern_gen.sv
// Eight vertical colour bars from the horizontal pixel position.
// Only built when FWC_TEST_PATTERN_EN is defined.
`ifdef FWC_TEST_PATTERN_EN
module fwc_pattern_gen #(
    parameter int H_PIX  = ov7670_pkg::H_PIX,
    parameter int XW     = $clog2(ov7670_pkg::H_PIX),
    parameter int DATA_W = ov7670_pkg::DATA_W
) (
    input  logic [XW-1:0]     x_cnt_i,
    output logic [DATA_W-1:0] rgb_o
);
    import ov7670_pkg::*;

    localparam int unsigned BAR_W = H_PIX / 8;

    assign rgb_o = DATA_W'(bar_colour(32'(x_cnt_i) / BAR_W));

endmodule
`endif

// File: rtl/frame_write_ctrl.sv
// Ping-pong frame-buffer write controller: commits only frames with the exact pixel count.
// Optional FWC_TEST_PATTERN_EN adds a pattern_en input that substitutes colour bars for pixel data.
module frame_write_ctrl #(
    parameter int H_PIX   = ov7670_pkg::H_PIX,
    parameter int V_LINES = ov7670_pkg::V_LINES,
    parameter int ADDR_W  = ov7670_pkg::ADDR_W,
    parameter int DATA_W  = ov7670_pkg::DATA_W
) (
    input  logic              pclk,
    input  logic              rst_n,
`ifdef FWC_TEST_PATTERN_EN
    input  logic              pattern_en,
`endif
    input  logic              vsync,
    input  logic              cap_we,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_dout,
    output logic              fb_we,
    output logic [ADDR_W:0]   fb_addr,
    output logic [DATA_W-1:0] fb_din,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);
    import ov7670_pkg::*;

    localparam int              FRAME_PIX   = H_PIX * V_LINES;
    localparam logic [ADDR_W:0] FRAME_PIX_W = (ADDR_W+1)'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] PIX_MAX   = '1;

    fwc_state_e          state_q, state_d;
    logic                vs_q;
    logic                vs_rise, vs_fall;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W:0]     fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]   fb_din_q, fb_din_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic [ADDR_W:0]     total;
    logic                in_range;
    logic                accept;
    logic [DATA_W-1:0]   pix_data;

    assign vs_rise  = vsync & ~vs_q;
    assign vs_fall  = ~vsync & vs_q;
    assign in_range = {1'b0, cap_addr} < FRAME_PIX_W;
    assign accept   = cap_we & (state_q == ACTIVE) & in_range;
    // One bit wider than pix_cnt so a coincident write on a saturated count cannot wrap
    assign total    = {1'b0, pix_cnt_q} + {{ADDR_W{1'b0}}, cap_we};

`ifdef FWC_TEST_PATTERN_EN
    localparam int XW = $clog2(H_PIX);

    logic [XW-1:0]     x_cnt_q, x_cnt_d;
    logic [DATA_W-1:0] bar_rgb;

    fwc_pattern_gen #(
        .H_PIX  (H_PIX),
        .XW     (XW),
        .DATA_W (DATA_W)
    ) u_pattern_gen (
        .x_cnt_i (x_cnt_q),
        .rgb_o   (bar_rgb)
    );

    always_comb begin
        x_cnt_d = x_cnt_q;
        if (state_q == VBLANK) begin
            x_cnt_d = '0;
        end else if (accept) begin
            x_cnt_d = (x_cnt_q == XW'(H_PIX - 1)) ? '0 : x_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q <= '0;
        end else begin
            x_cnt_q <= x_cnt_d;
        end
    end

    assign pix_data = pattern_en ? bar_rgb : cap_dout;
`else
    assign pix_data = cap_dout;
`endif

    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        fb_we_d      = accept;
        fb_addr_d    = accept ? {wr_bank_q, cap_addr} : fb_addr_q;
        fb_din_d     = accept ? pix_data : fb_din_q;

        case (state_q)
            SYNC: begin
                if (vs_rise) begin
                    state_d = VBLANK;
                end
            end
            VBLANK: begin
                pix_cnt_d = '0;
                if (vs_fall) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cap_we && (pix_cnt_q != PIX_MAX)) begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (vs_rise) begin
                    state_d = VBLANK;
                    if (total == FRAME_PIX_W) begin
                        rd_bank_d    = wr_bank_q;
                        wr_bank_d    = ~wr_bank_q;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            vs_q         <= 1'b0;
            wr_bank_q    <= 1'b1;
            rd_bank_q    <= 1'b0;
            pix_cnt_q    <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_din_q     <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            vs_q         <= vsync;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            pix_cnt_q    <= pix_cnt_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_din_q     <= fb_din_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_din     = fb_din_q;
    assign rd_bank    = rd_bank_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Bench for frame_write_ctrl on a reduced 16x4 frame (64 pixels, 7-bit addresses).
module tb_frame_write_ctrl;

    localparam int AW  = 7;
    localparam int DW  = 12;
    localparam int HP  = 16;
    localparam int VL  = 4;
    localparam int FP  = HP * VL;
    localparam int SAT = (1 << AW) - 1;
`ifdef FWC_TEST_PATTERN_EN
    localparam bit PAT_BUILD = 1'b1;
`else
    localparam bit PAT_BUILD = 1'b0;
`endif

    logic          pclk = 1'b0;
    logic          rst_n;
    logic          pattern_en;
    logic          vsync;
    logic          cap_we;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_dout;
    logic          fb_we;
    logic [AW:0]   fb_addr;
    logic [DW-1:0] fb_din;
    logic          rd_bank;
    logic          frame_done;
    logic          frame_err;
    logic [7:0]    frame_cnt;

    frame_write_ctrl #(
        .H_PIX   (HP),
        .V_LINES (VL),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .pclk       (pclk),
        .rst_n      (rst_n),
`ifdef FWC_TEST_PATTERN_EN
        .pattern_en (pattern_en),
`endif
        .vsync      (vsync),
        .cap_we     (cap_we),
        .cap_addr   (cap_addr),
        .cap_dout   (cap_dout),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_din     (fb_din),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;

    // reference model: frame-level bookkeeping from the behavioural rules
    bit          m_vs_prev, m_armed, m_active, m_wr, m_rd;
    int          m_count, m_x, m_frames;
    logic        e_we, e_done, e_err;
    logic [AW:0] e_addr;
    logic [DW-1:0] e_din;
    bit          saw_done, saw_err;
    int          we_hits;

    typedef struct {
        logic          vs;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout;
        logic          x_we;
        logic [AW:0]   x_addr;
        logic [DW-1:0] x_din;
        logic          x_err;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [DW-1:0] bar_col(input int i);
        case (i)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        m_vs_prev = 0; m_armed = 0; m_active = 0;
        m_wr = 1; m_rd = 0;
        m_count = 0; m_x = 0; m_frames = 0;
        e_we = 0; e_done = 0; e_err = 0; e_addr = '0; e_din = '0;
    endtask

    task automatic model_step(input logic vs, input logic we,
                              input logic [AW-1:0] addr, input logic [DW-1:0] dout);
        bit rise, fall, acc;
        int total;
        rise = vs && !m_vs_prev;
        fall = !vs && m_vs_prev;
        acc  = we && m_active && (int'(addr) < FP);
        e_we = acc; e_done = 0; e_err = 0;
        if (acc) begin
            e_addr = {m_wr, addr};
            e_din  = (PAT_BUILD && pattern_en) ? bar_col(m_x / (HP / 8)) : dout;
            m_x    = (m_x + 1) % HP;
        end
        if (m_active) begin
            total   = m_count + (we ? 1 : 0);
            m_count = (total > SAT) ? SAT : total;
            if (rise) begin
                if (total == FP) begin
                    m_rd = m_wr; m_wr = !m_wr;
                    m_frames = (m_frames + 1) % 256;
                    e_done = 1;
                end else begin
                    e_err = 1;
                end
                m_active = 0; m_count = 0; m_x = 0;
            end
        end else if (rise) begin
            m_armed = 1;
        end else if (fall && m_armed) begin
            m_active = 1; m_count = 0; m_x = 0;
        end
        m_vs_prev = vs;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic cycle(input logic vs, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] dout);
        vsync = vs; cap_we = we; cap_addr = addr; cap_dout = dout;
        model_step(vs, we, addr, dout);
        @(posedge pclk);
        #1;
        checks++;
        if (fb_we !== e_we || fb_addr !== e_addr || fb_din !== e_din ||
            frame_done !== e_done || frame_err !== e_err ||
            rd_bank !== m_rd || frame_cnt !== 8'(m_frames)) begin
            errors++;
            $display("FAIL cycle t=%0t got we=%b addr=%h din=%h done=%b err=%b rd=%b cnt=%0d expected we=%b addr=%h din=%h done=%b err=%b rd=%b cnt=%0d",
                     $time, fb_we, fb_addr, fb_din, frame_done, frame_err, rd_bank, frame_cnt,
                     e_we, e_addr, e_din, e_done, e_err, m_rd, m_frames);
        end
        if (frame_done === 1'b1) saw_done = 1;
        if (frame_err === 1'b1) saw_err = 1;
        if (fb_we === 1'b1) we_hits++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vsync = 0; cap_we = 0; cap_addr = '0; cap_dout = '0;
        #3;
        model_reset();
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_din", int'(fb_din), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_rd_bank", int'(rd_bank), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        @(negedge pclk);
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int n, input bit coinc, input int oor_at,
                             input int glitch_at, input bit gaps);
        saw_done = 0; saw_err = 0;
        cycle(1, 0, '0, '0);
        cycle(1, 0, '0, '0);
        cycle(0, 0, '0, '0);
        for (int i = 0; i < n; i++) begin
            if (i == oor_at) cycle(0, 1, AW'(FP), DW'($urandom));
            if (i == glitch_at) begin
                cycle(1, 0, '0, '0);
                cycle(0, 0, '0, '0);
            end
            if (gaps && $urandom_range(0, 3) == 0)
                cycle(0, 0, AW'($urandom_range(0, FP - 1)), DW'($urandom));
            if (coinc && i == n - 1) cycle(1, 1, AW'(i % FP), DW'($urandom));
            else                     cycle(0, 1, AW'(i % FP), DW'($urandom));
        end
        if (!coinc) cycle(1, 0, '0, '0);
        cycle(1, 0, '0, '0);
    endtask

    initial begin
        pattern_en = 1'b0;
        // SYNC/VBLANK/ACTIVE walk-through with a short frame; banks start wr=1, rd=0
        tbl[0] = '{1'b0, 1'b1, 7'd5,  12'hABC, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 7'd6,  12'hABD, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 7'd7,  12'hABE, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 7'd8,  12'h123, 1'b0, 8'h00, 12'h000, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 7'd0,  12'h321, 1'b1, 8'h80, 12'h321, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 7'd1,  12'h555, 1'b0, 8'h80, 12'h321, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 7'd64, 12'h777, 1'b0, 8'h80, 12'h321, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 7'd63, 12'h0F0, 1'b1, 8'hBF, 12'h0F0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 7'd0,  12'h000, 1'b0, 8'hBF, 12'h0F0, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 7'd0,  12'h000, 1'b0, 8'hBF, 12'h0F0, 1'b0};

        do_reset();

        // a full frame's worth of writes before any vsync rise is ignored
        we_hits = 0; saw_done = 0; saw_err = 0;
        for (int i = 0; i < FP; i++) cycle(0, 1, AW'(i), DW'($urandom));
        check("sync_no_we", we_hits, 0);
        check("sync_no_pulse", int'(saw_done | saw_err), 0);

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].vs, tbl[i].we, tbl[i].addr, tbl[i].dout);
            checks++;
            if (fb_we !== tbl[i].x_we || fb_addr !== tbl[i].x_addr ||
                fb_din !== tbl[i].x_din || frame_err !== tbl[i].x_err) begin
                errors++;
                $display("FAIL vec%0d got we=%b addr=%h din=%h err=%b expected we=%b addr=%h din=%h err=%b",
                         i, fb_we, fb_addr, fb_din, frame_err,
                         tbl[i].x_we, tbl[i].x_addr, tbl[i].x_din, tbl[i].x_err);
            end
        end

        run_frame(FP, 0, -1, -1, 0);
        check("full_done", int'(saw_done), 1);
        check("full_rd_bank", int'(rd_bank), 1);
        check("full_cnt", int'(frame_cnt), 1);

        run_frame(FP - 1, 0, -1, -1, 0);
        check("short_err", int'(saw_err), 1);
        check("short_rd_bank", int'(rd_bank), 1);
        check("short_cnt", int'(frame_cnt), 1);

        run_frame(FP, 0, -1, -1, 0);
        check("bank0_done", int'(saw_done), 1);
        check("bank0_rd_bank", int'(rd_bank), 0);
        check("bank0_last_addr", int'(fb_addr), FP - 1);

        run_frame(FP, 1, -1, -1, 0);
        check("coinc_done", int'(saw_done), 1);
        check("coinc_rd_bank", int'(rd_bank), 1);
        check("coinc_cnt", int'(frame_cnt), 3);

        run_frame(FP, 0, 20, -1, 0);
        check("oor_err", int'(saw_err), 1);
        check("oor_no_done", int'(saw_done), 0);

        // 192 writes: a wrapping 7-bit count would read back as exactly 64
        run_frame(FP + 128, 0, -1, -1, 0);
        check("sat_err", int'(saw_err), 1);
        check("sat_no_done", int'(saw_done), 0);

        run_frame(FP, 0, -1, 10, 0);
        check("glitch_err", int'(saw_err), 1);
        check("glitch_no_done", int'(saw_done), 0);
        check("glitch_cnt", int'(frame_cnt), 3);

`ifdef FWC_TEST_PATTERN_EN
        pattern_en = 1'b1;
        cycle(1, 0, '0, '0);
        cycle(0, 0, '0, '0);
        for (int i = 0; i < HP; i++) begin
            cycle(0, 1, AW'(i), 12'h000);
            if (i == 0 || i == 1) check("pat_white", int'(fb_din), 'hFFF);
            if (i == 2 || i == 3) check("pat_yellow", int'(fb_din), 'hFF0);
            if (i == 4) check("pat_cyan", int'(fb_din), 'h0FF);
            if (i == 14 || i == 15) check("pat_black", int'(fb_din), 'h000);
        end
        pattern_en = 1'b0;
        cycle(1, 0, '0, '0);
`endif

        // reset in the middle of a frame while the display is on bank 1
        cycle(1, 0, '0, '0);
        cycle(0, 0, '0, '0);
        for (int i = 0; i < 10; i++) cycle(0, 1, AW'(i), DW'($urandom));
        do_reset();
        run_frame(FP, 0, -1, -1, 0);
        check("post_rst_done", int'(saw_done), 1);
        check("post_rst_rd_bank", int'(rd_bank), 1);
        check("post_rst_cnt", int'(frame_cnt), 1);

        for (int f = 0; f < 40; f++) begin
            int r, n;
            r = int'($urandom_range(0, 5));
            n = (r <= 2) ? FP : (r == 3) ? FP - 1 : (r == 4) ? FP + 1
                         : int'($urandom_range(1, 140));
            pattern_en = 1'($urandom_range(0, 1));
            run_frame(n, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1,
                      1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
